rob_mr: RTL and testbench

- Parametrised reorder buffer and retirement unit; successor to the single-retire ROB.
- Accepts one decoded instruction per cycle and takes writebacks from WB_PORTS independent writeback buses.
- Retires up to RET_W instructions per cycle, in order.
- Sits between decode/wb and the RAT, brpred, LSQ, CSR and fetch. Enforces at most one branch and one store per retire group.

---
 rtl/rob_mr.sv | 240 ++++++++++++++++++++++++
 tb/tb_rob_mr.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mr.sv
// rob_mr: parametrised reorder buffer that retires up to RET_W instructions per cycle, in order.
// Define ROB_PERF_EN to add saturating retired-instruction and flush counters.
module rob_mr #(
  parameter int DEPTH    = 128,
  parameter int RET_W    = 2,
  parameter int WB_PORTS = 2,
  localparam int IDW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     decode_rob_valid,
  input  logic                     decode_error,
  input  logic [4:0]               decode_ecause,
  input  logic [6:0]               decode_retop,
  input  logic [29:0]              decode_addr,
  input  logic [5:0]               decode_rd,
  input  logic [15:0]              decode_bptag,
  input  logic                     decode_bptaken,
  input  logic                     decode_forward,
  input  logic [29:0]              decode_target,
  output logic                     rob_full,
  output logic [IDW-1:0]           rob_robid,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS-1:0]      wb_error,
  input  logic [5*WB_PORTS-1:0]    wb_ecause,
  input  logic [IDW*WB_PORTS-1:0]  wb_robid,
  input  logic [32*WB_PORTS-1:0]   wb_result,
  output logic                     rob_flush,
  output logic [29:0]              rob_flush_pc,
  output logic [RET_W-1:0]         rob_ret_valid,
  output logic [5*RET_W-1:0]       rob_ret_rd,
  output logic [32*RET_W-1:0]      rob_ret_result,
  output logic                     rob_ret_branch,
  output logic [15:0]              rob_ret_bptag,
  output logic                     rob_ret_bptaken,
  output logic                     rob_ret_store,
  input  logic [29:0]              csr_tvec,
  output logic                     rob_csr_valid,
  output logic [29:0]              rob_csr_epc,
  output logic [4:0]               rob_csr_ecause,
  output logic [31:0]              rob_csr_tval
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]              perf_retired,
  output logic [15:0]              perf_flushes
`endif
);

  localparam int CW = IDW + 1;

  function automatic logic mispredict(input logic [6:0] retop, input logic res0, input logic bpt);
    return retop[4] | (retop[6] & ((res0 ^ retop[5]) ^ bpt));
  endfunction

  logic [CW-1:0]  head_q, tail_q, count, grp_sz;
  logic           do_insert;
  logic [IDW-1:0] tail_idx;
  logic [IDW-1:0] slot_idx [RET_W];
  logic [RET_W-1:0] take;

  logic        ent_exec   [DEPTH];
  logic        ent_err    [DEPTH];
  logic [4:0]  ent_ecause [DEPTH];
  logic [31:0] ent_result [DEPTH];
  logic [6:0]  ent_retop  [DEPTH];
  logic [29:0] ent_addr   [DEPTH];
  logic [5:0]  ent_rd     [DEPTH];
  logic [15:0] ent_bptag  [DEPTH];
  logic        ent_bpt    [DEPTH];
  logic        ent_fwd    [DEPTH];
  logic [29:0] ent_tgt    [DEPTH];

  logic [RET_W-1:0] slot_v_q;
  logic        slot_err    [RET_W];
  logic [4:0]  slot_ecause [RET_W];
  logic [31:0] slot_result [RET_W];
  logic [6:0]  slot_retop  [RET_W];
  logic [29:0] slot_addr   [RET_W];
  logic [5:0]  slot_rd     [RET_W];
  logic [15:0] slot_bptag  [RET_W];
  logic        slot_bpt    [RET_W];
  logic        slot_fwd    [RET_W];
  logic [29:0] slot_tgt    [RET_W];

  assign tail_idx  = tail_q[IDW-1:0];
  assign count     = tail_q - head_q;
  assign rob_full  = (head_q[IDW-1:0] == tail_idx) && (head_q[IDW] != tail_q[IDW]);
  assign rob_robid = tail_idx;
  assign do_insert = decode_rob_valid & ~rob_full & ~rob_flush;

  for (genvar g = 0; g < RET_W; g++) begin : g_slot
    assign slot_idx[g] = head_q[IDW-1:0] + IDW'(g);
  end

  // Retire group: executed prefix, one branch/store each, ending at the first redirecting slot.
  always_comb begin
    logic stop, seen_br, seen_st;
    stop    = 1'b0;
    seen_br = 1'b0;
    seen_st = 1'b0;
    take    = '0;
    grp_sz  = '0;
    for (int i = 0; i < RET_W; i++) begin
      if (!stop) begin
        if (CW'(i) < count && ent_exec[slot_idx[i]] &&
            !(ent_retop[slot_idx[i]][6] && seen_br) &&
            !(ent_retop[slot_idx[i]][3] && seen_st)) begin
          take[i] = 1'b1;
          grp_sz  = grp_sz + CW'(1);
          seen_br = seen_br | ent_retop[slot_idx[i]][6];
          seen_st = seen_st | ent_retop[slot_idx[i]][3];
          if (ent_err[slot_idx[i]] ||
              mispredict(ent_retop[slot_idx[i]], ent_result[slot_idx[i]][0], ent_bpt[slot_idx[i]]))
            stop = 1'b1;
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      slot_v_q <= '0;
    end else if (rob_flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      slot_v_q <= '0;
    end else begin
      head_q   <= head_q + grp_sz;
      slot_v_q <= take;
      if (do_insert) tail_q <= tail_q + CW'(1);
    end
  end

  // Entry storage is deliberately unreset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_insert) begin
      ent_exec[tail_idx]   <= decode_error | decode_retop[3];
      ent_err[tail_idx]    <= decode_error;
      ent_ecause[tail_idx] <= decode_ecause;
      ent_result[tail_idx] <= '0;
      ent_retop[tail_idx]  <= decode_retop;
      ent_addr[tail_idx]   <= decode_addr;
      ent_rd[tail_idx]     <= decode_rd;
      ent_bptag[tail_idx]  <= decode_bptag;
      ent_bpt[tail_idx]    <= decode_bptaken;
      ent_fwd[tail_idx]    <= decode_forward;
      ent_tgt[tail_idx]    <= decode_target;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        ent_exec[wb_robid[p*IDW +: IDW]]   <= 1'b1;
        ent_err[wb_robid[p*IDW +: IDW]]    <= wb_error[p];
        ent_ecause[wb_robid[p*IDW +: IDW]] <= wb_ecause[p*5 +: 5];
        ent_result[wb_robid[p*IDW +: IDW]] <= wb_result[p*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RET_W; i++) begin
      slot_err[i]    <= ent_err[slot_idx[i]];
      slot_ecause[i] <= ent_ecause[slot_idx[i]];
      slot_result[i] <= ent_result[slot_idx[i]];
      slot_retop[i]  <= ent_retop[slot_idx[i]];
      slot_addr[i]   <= ent_addr[slot_idx[i]];
      slot_rd[i]     <= ent_rd[slot_idx[i]];
      slot_bptag[i]  <= ent_bptag[slot_idx[i]];
      slot_bpt[i]    <= ent_bpt[slot_idx[i]];
      slot_fwd[i]    <= ent_fwd[slot_idx[i]];
      slot_tgt[i]    <= ent_tgt[slot_idx[i]];
    end
  end

  // Every output is gated by slot validity so reset and flush read as all zeros.
  always_comb begin
    logic br;
    br              = 1'b0;
    rob_ret_valid   = '0;
    rob_ret_rd      = '0;
    rob_ret_result  = '0;
    rob_ret_branch  = 1'b0;
    rob_ret_bptag   = '0;
    rob_ret_bptaken = 1'b0;
    rob_ret_store   = 1'b0;
    rob_csr_valid   = 1'b0;
    rob_csr_epc     = '0;
    rob_csr_ecause  = '0;
    rob_flush       = 1'b0;
    rob_flush_pc    = '0;
    for (int i = 0; i < RET_W; i++) begin
      if (slot_v_q[i]) begin
        br = slot_result[i][0] ^ slot_retop[i][5];
        if (!slot_err[i] && !slot_rd[i][5]) begin
          rob_ret_valid[i]          = 1'b1;
          rob_ret_rd[i*5 +: 5]      = slot_rd[i][4:0];
          rob_ret_result[i*32 +: 32] = slot_fwd[i] ? {slot_tgt[i], 2'b00} : slot_result[i];
        end
        if (!slot_err[i] && slot_retop[i][6]) begin
          rob_ret_branch  = 1'b1;
          rob_ret_bptag   = slot_bptag[i];
          rob_ret_bptaken = br;
        end
        if (!slot_err[i] && slot_retop[i][3]) rob_ret_store = 1'b1;
        if (slot_err[i]) begin
          rob_csr_valid  = 1'b1;
          rob_csr_epc    = slot_addr[i];
          rob_csr_ecause = slot_ecause[i];
        end
        if (slot_err[i] || mispredict(slot_retop[i], slot_result[i][0], slot_bpt[i])) begin
          rob_flush    = 1'b1;
          rob_flush_pc = slot_err[i] ? csr_tvec :
                         (slot_fwd[i] ? slot_result[i][31:2] : slot_tgt[i]);
        end
      end
    end
  end

  assign rob_csr_tval = '0;

`ifdef ROB_PERF_EN
  logic [32:0] ret_sum;
  assign ret_sum = {1'b0, perf_retired} + 33'(grp_sz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else if (rob_flush) begin
      if (perf_flushes != '1) perf_flushes <= perf_flushes + 16'd1;
    end else begin
      perf_retired <= ret_sum[32] ? '1 : ret_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_rob_mr.sv
// tb_rob_mr: directed and randomized checks of rob_mr (DEPTH=4, RET_W=2, WB_PORTS=2)
// against a queue-based reference model of in-order retirement.
module tb_rob_mr;
  localparam int DEPTH = 4, RET_W = 2, WB_PORTS = 2, IDW = 2;

  logic clk = 1'b0;
  logic rst;
  logic decode_rob_valid, decode_error, decode_bptaken, decode_forward;
  logic [4:0] decode_ecause;
  logic [6:0] decode_retop;
  logic [29:0] decode_addr, decode_target, csr_tvec;
  logic [5:0] decode_rd;
  logic [15:0] decode_bptag;
  logic rob_full, rob_flush, rob_ret_branch, rob_ret_bptaken, rob_ret_store, rob_csr_valid;
  logic [IDW-1:0] rob_robid;
  logic [WB_PORTS-1:0] wb_valid, wb_error;
  logic [5*WB_PORTS-1:0] wb_ecause;
  logic [IDW*WB_PORTS-1:0] wb_robid;
  logic [32*WB_PORTS-1:0] wb_result;
  logic [29:0] rob_flush_pc, rob_csr_epc;
  logic [RET_W-1:0] rob_ret_valid;
  logic [5*RET_W-1:0] rob_ret_rd;
  logic [32*RET_W-1:0] rob_ret_result;
  logic [15:0] rob_ret_bptag;
  logic [4:0] rob_csr_ecause;
  logic [31:0] rob_csr_tval;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int id; bit exec; bit err; bit [4:0] ec; bit [31:0] res; bit [6:0] retop;
    bit [29:0] addr; bit [5:0] rd; bit [15:0] tag; bit bpt; bit fwd; bit [29:0] tgt;
  } ent_t;

  ent_t robq[$];
  ent_t grp[$];
  int tail_id;

  rob_mr #(.DEPTH(DEPTH), .RET_W(RET_W), .WB_PORTS(WB_PORTS)) dut (
    .clk(clk), .rst(rst),
    .decode_rob_valid(decode_rob_valid), .decode_error(decode_error),
    .decode_ecause(decode_ecause), .decode_retop(decode_retop), .decode_addr(decode_addr),
    .decode_rd(decode_rd), .decode_bptag(decode_bptag), .decode_bptaken(decode_bptaken),
    .decode_forward(decode_forward), .decode_target(decode_target),
    .rob_full(rob_full), .rob_robid(rob_robid),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_ecause(wb_ecause),
    .wb_robid(wb_robid), .wb_result(wb_result),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc),
    .rob_ret_valid(rob_ret_valid), .rob_ret_rd(rob_ret_rd), .rob_ret_result(rob_ret_result),
    .rob_ret_branch(rob_ret_branch), .rob_ret_bptag(rob_ret_bptag),
    .rob_ret_bptaken(rob_ret_bptaken), .rob_ret_store(rob_ret_store),
    .csr_tvec(csr_tvec), .rob_csr_valid(rob_csr_valid), .rob_csr_epc(rob_csr_epc),
    .rob_csr_ecause(rob_csr_ecause), .rob_csr_tval(rob_csr_tval)
  );

  always #5 clk = ~clk;

  function automatic bit isMisp(ent_t e);
    bit br;
    br = e.res[0] ^ e.retop[5];
    return e.retop[4] | (e.retop[6] & (br ^ e.bpt));
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    decode_rob_valid = 0; decode_error = 0; decode_ecause = 0; decode_retop = 0;
    decode_addr = 0; decode_rd = 0; decode_bptag = 0; decode_bptaken = 0;
    decode_forward = 0; decode_target = 0;
    wb_valid = 0; wb_error = 0; wb_ecause = 0; wb_robid = 0; wb_result = 0;
  endtask

  task automatic setInsert(input bit [6:0] retop, input bit [5:0] rd, input bit [29:0] addr,
                           input bit [29:0] tgt, input bit bpt, input bit fwd,
                           input bit err, input bit [4:0] ec);
    decode_rob_valid = 1; decode_retop = retop; decode_rd = rd; decode_addr = addr;
    decode_target = tgt; decode_bptaken = bpt; decode_forward = fwd;
    decode_error = err; decode_ecause = ec; decode_bptag = 16'($urandom);
  endtask

  task automatic setWb(input int p, input int id, input bit err, input bit [4:0] ec,
                       input bit [31:0] res);
    wb_valid[p] = 1'b1;
    wb_error[p] = err;
    wb_ecause[p*5 +: 5] = ec;
    wb_robid[p*IDW +: IDW] = IDW'(id);
    wb_result[p*32 +: 32] = res;
  endtask

  task automatic modelClear();
    robq.delete();
    grp.delete();
    tail_id = 0;
  endtask

  // Expected outputs follow directly from the model's registered retire group.
  task automatic checkOutput();
    logic [RET_W-1:0] ev; logic [5*RET_W-1:0] erd; logic [32*RET_W-1:0] eres;
    logic ebr, ebpt, est, ecv, efl, br;
    logic [15:0] etag; logic [29:0] eepc, efpc; logic [4:0] eec;
    ev = '0; erd = '0; eres = '0; ebr = 0; ebpt = 0; est = 0; ecv = 0; efl = 0; br = 0;
    etag = '0; eepc = '0; efpc = '0; eec = '0;
    for (int i = 0; i < grp.size(); i++) begin
      br = grp[i].res[0] ^ grp[i].retop[5];
      if (!grp[i].err && !grp[i].rd[5]) begin
        ev[i] = 1'b1;
        erd[i*5 +: 5] = grp[i].rd[4:0];
        eres[i*32 +: 32] = grp[i].fwd ? {grp[i].tgt, 2'b00} : grp[i].res;
      end
      if (!grp[i].err && grp[i].retop[6]) begin ebr = 1; etag = grp[i].tag; ebpt = br; end
      if (!grp[i].err && grp[i].retop[3]) est = 1;
      if (grp[i].err) begin ecv = 1; eepc = grp[i].addr; eec = grp[i].ec; end
      if (grp[i].err || isMisp(grp[i])) begin
        efl = 1;
        efpc = grp[i].err ? csr_tvec : (grp[i].fwd ? grp[i].res[31:2] : grp[i].tgt);
      end
    end
    checkVal("full", rob_full, robq.size() == DEPTH);
    checkVal("robid", rob_robid, tail_id);
    checkVal("ret_valid", rob_ret_valid, ev);
    checkVal("ret_rd", rob_ret_rd, erd);
    checkVal("ret_result", rob_ret_result, eres);
    checkVal("ret_branch", rob_ret_branch, ebr);
    checkVal("ret_bptag", rob_ret_bptag, etag);
    checkVal("ret_bptaken", rob_ret_bptaken, ebpt);
    checkVal("ret_store", rob_ret_store, est);
    checkVal("csr_valid", rob_csr_valid, ecv);
    checkVal("csr_epc", rob_csr_epc, eepc);
    checkVal("csr_ecause", rob_csr_ecause, eec);
    checkVal("csr_tval", rob_csr_tval, 0);
    checkVal("flush", rob_flush, efl);
    checkVal("flush_pc", rob_flush_pc, efpc);
  endtask

  // Advance one clock with the current inputs and update the model the same way.
  task automatic applyStimulus();
    bit fl, full_pre, nbr, nst;
    ent_t e;
    fl = 0;
    foreach (grp[i]) if (grp[i].err || isMisp(grp[i])) fl = 1;
    full_pre = (robq.size() == DEPTH);
    @(posedge clk);
    #1;
    grp.delete();
    if (fl) begin
      robq.delete();
      tail_id = 0;
      return;
    end
    nbr = 0; nst = 0;
    for (int i = 0; i < RET_W && robq.size() > 0; i++) begin
      e = robq[0];
      if (!e.exec || (e.retop[6] && nbr) || (e.retop[3] && nst)) break;
      nbr |= e.retop[6];
      nst |= e.retop[3];
      void'(robq.pop_front());
      grp.push_back(e);
      if (e.err || isMisp(e)) break;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        foreach (robq[k]) begin
          if (robq[k].id == int'(wb_robid[p*IDW +: IDW])) begin
            robq[k].exec = 1; robq[k].err = wb_error[p];
            robq[k].ec = wb_ecause[p*5 +: 5]; robq[k].res = wb_result[p*32 +: 32];
          end
        end
      end
    end
    if (decode_rob_valid && !full_pre) begin
      e.id = tail_id; e.exec = decode_error | decode_retop[3]; e.err = decode_error;
      e.ec = decode_ecause; e.res = 0; e.retop = decode_retop; e.addr = decode_addr;
      e.rd = decode_rd; e.tag = decode_bptag; e.bpt = decode_bptaken;
      e.fwd = decode_forward; e.tgt = decode_target;
      robq.push_back(e);
      tail_id = (tail_id + 1) % DEPTH;
    end
  endtask

  task automatic step();
    #1;
    checkOutput();
    applyStimulus();
    idleInputs();
  endtask

  task automatic doReset();
    rst = 1;
    idleInputs();
    modelClear();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst = 0;
  endtask

  initial begin
    int sel, pick;
    bit [6:0] op;
    bit [5:0] rd;
    int open_ids[$];
    csr_tvec = 30'h80;
    doReset();

    // Four ALU ops fill the buffer; a fifth insert is dropped; two 2-wide retires follow.
    for (int i = 1; i <= 4; i++) begin
      setInsert(7'b0, 6'(i), 30'(i), 30'h0, 0, 0, 0, 0);
      step();
    end
    checkVal("t1_full", rob_full, 1);
    setInsert(7'b0, 6'd5, 30'h5, 30'h0, 0, 0, 0, 0);
    setWb(0, 0, 0, 0, 32'h11);
    setWb(1, 1, 0, 0, 32'h12);
    step();
    checkVal("t1_wrap_robid", rob_robid, 0);
    setWb(0, 2, 0, 0, 32'h13);
    setWb(1, 3, 0, 0, 32'h14);
    step();
    checkVal("t1_valid_a", rob_ret_valid, 2'b11);
    checkVal("t1_result_a", rob_ret_result, 64'h00000012_00000011);
    checkVal("t1_not_full", rob_full, 0);
    step();
    checkVal("t1_valid_b", rob_ret_valid, 2'b11);
    checkVal("t1_result_b", rob_ret_result, 64'h00000014_00000013);
    step();

    // Two stores visible together at the head retire on separate cycles.
    setInsert(7'b0, 6'd7, 30'h10, 0, 0, 0, 0, 0); step();
    setInsert(7'b0, 6'd8, 30'h11, 0, 0, 0, 0, 0); step();
    setInsert(7'b0001000, 6'h20, 30'h12, 0, 0, 0, 0, 0); step();
    setInsert(7'b0001000, 6'h20, 30'h13, 0, 0, 0, 0, 0); step();
    setWb(0, 1, 0, 0, 32'h21); step();
    setWb(1, 0, 0, 0, 32'h20); step();
    step();
    step();
    checkVal("t2_store_a", rob_ret_store, 1);
    step();
    checkVal("t2_store_b", rob_ret_store, 1);
    step();

    // Mispredicted not-taken branch flushes to its static target.
    setInsert(7'b1000000, 6'h20, 30'h400, 30'h40, 1, 0, 0, 0); step();
    setInsert(7'b0, 6'd9, 30'h401, 0, 0, 0, 0, 0); step();
    setWb(0, 0, 0, 0, 32'h0);
    setWb(1, 1, 0, 0, 32'h55);
    step();
    step();
    checkVal("t3_flush", rob_flush, 1);
    checkVal("t3_flush_pc", rob_flush_pc, 30'h40);
    checkVal("t3_bptaken", rob_ret_bptaken, 0);
    checkVal("t3_valid", rob_ret_valid, 0);
    step();
    checkVal("t3_robid", rob_robid, 0);
    checkVal("t3_no_alu", rob_ret_valid, 0);
    step();

    // Writeback fault raises an exception to the trap vector.
    setInsert(7'b0, 6'd3, 30'h123, 0, 0, 0, 0, 0); step();
    setWb(0, 0, 1, 5'd5, 32'hdead); step();
    step();
    checkVal("t4_csr_valid", rob_csr_valid, 1);
    checkVal("t4_epc", rob_csr_epc, 30'h123);
    checkVal("t4_ecause", rob_csr_ecause, 5);
    checkVal("t4_flush_pc", rob_flush_pc, 30'h80);
    checkVal("t4_valid", rob_ret_valid, 0);
    step();

    // Reset while a group is presented clears the retire outputs at once.
    setInsert(7'b0, 6'd1, 30'h200, 0, 0, 0, 0, 0); step();
    setInsert(7'b0, 6'd2, 30'h201, 0, 0, 0, 0, 0); step();
    setWb(0, 0, 0, 0, 32'h31);
    setWb(1, 1, 0, 0, 32'h32);
    step();
    step();
    checkVal("t5_pre_valid", rob_ret_valid, 2'b11);
    rst = 1;
    modelClear();
    #1;
    checkVal("t5_valid", rob_ret_valid, 0);
    checkVal("t5_robid", rob_robid, 0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 0;

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 70) begin
        sel = $urandom_range(0, 5);
        case (sel)
          2: op = 7'b0001000;
          3: op = 7'b1000000;
          4: op = 7'b1100000;
          5: op = 7'b0010000;
          default: op = 7'b0;
        endcase
        rd = ($urandom_range(0, 3) == 0) ? 6'h20 : {1'b0, 5'($urandom)};
        setInsert(op, rd, 30'($urandom), 30'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 5'($urandom));
      end
      open_ids.delete();
      foreach (robq[k]) if (!robq[k].exec) open_ids.push_back(robq[k].id);
      for (int p = 0; p < WB_PORTS; p++) begin
        if (open_ids.size() > 0 && $urandom_range(0, 1) == 1) begin
          pick = open_ids[$urandom_range(0, open_ids.size() - 1)];
          setWb(p, pick, $urandom_range(0, 15) == 0, 5'($urandom), $urandom);
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
